key_event: RTL and testbench
============================

Name: key_event

Overview:
- Consumer-side counterpart to the board's button debouncer.
- Takes a clean, debounced key level and turns it into single-cycle user-interface events: press, release, short press, long press and auto-repeat.
- Also keeps a wrapping press counter.
- Sits between the debouncer output and control FSMs or display logic.

Parameters:
- N, 26, width of the hold counter; must satisfy 2^N > max(T_LONG, T_REPEAT).
- T_LONG, 26'h2FA_F080 (50_000_000 = 1 s at 50 MHz), consecutive high samples required for a long press.
- T_REPEAT, 26'h0BE_BC20 (12_500_000 = 250 ms), high samples between repeat events once long.
- CW, 8, width of press_cnt.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  debounced key level; 1 = pressed; already synchronous to clk.
- held  output  1  1 while the key is considered pressed (state != S_IDLE).
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on any release.
- short_pulse  output  1  one-cycle pulse on release before the long threshold.
- long_pulse  output  1  one-cycle pulse when the long threshold is reached.
- repeat_pulse  output  1  one-cycle pulse every T_REPEAT samples while long-held.
- press_cnt  output  CW  count of press events; wraps.

Behaviour:
- Reset: all outputs registered.
  - While rst=1: state=S_IDLE, cnt=0, press_cnt=0.
  - All pulses and held are 0.
  - Reset mid-hold discards the hold with no release or short pulse.
- States: S_IDLE, S_PRESS, S_LONG; 2-bit encoding, illegal code -> S_IDLE.
- S_IDLE:
  - din=1 at an edge -> S_PRESS, cnt=1, press_pulse=1, press_cnt+1.
  - Otherwise stay, cnt=0.
- S_PRESS:
  - din=0 -> S_IDLE, release_pulse=1, short_pulse=1, cnt=0.
  - din=1 and cnt+1==T_LONG -> S_LONG, long_pulse=1, cnt=0.
  - Otherwise cnt+1.
- S_LONG:
  - din=0 -> S_IDLE, release_pulse=1, short_pulse=0, cnt=0.
  - din=1 and cnt+1==T_REPEAT -> repeat_pulse=1, cnt=0.
  - Otherwise cnt+1.
- Timing: long_pulse occurs on the T_LONG-th consecutive edge sampling din=1, counting the entering edge. Repeats follow every T_REPEAT further high samples.
- Latency: pulses are visible in the cycle immediately after the sampling edge that caused them. No combinational path from din to any output.
- Exclusivity:
  - At most one of press/long/repeat per cycle.
  - release_pulse never coincides with press_pulse.
  - short_pulse only ever coincides with release_pulse.
- Boundaries:
  - Release on the edge where the count would reach T_LONG: din=0 there, so it is a short press with no long_pulse.
  - din high at reset deassertion: press_pulse on the first edge after release of rst.
  - press_cnt wraps from 2^CW-1 to 0 silently.
  - A one-sample press (din high for exactly one edge) gives press_pulse, then release_pulse+short_pulse on the next cycle.
- Arithmetic: cnt is unsigned N-bit; compares use exact equality; cnt never exceeds max(T_LONG, T_REPEAT).

Optional Feature:
- Macro KEY_EVENT_REPEAT_EN.
- Defined: auto-repeat operates as above.
- Undefined:
  - repeat_pulse is tied to 0.
  - In S_LONG, cnt holds at 0 and the state waits only for din=0.
  - T_REPEAT is unused.
  - All other behaviour is identical.

Test Plan (T_LONG=10, T_REPEAT=4, CW=8):
- Assert rst mid-run with din toggling -> all outputs 0 while rst=1, press_cnt=0; din high at deassert -> press_pulse on first edge after.
- din high 5 samples then low -> press_pulse 1 cycle after first high sample; release_pulse+short_pulse 1 cycle after first low sample; no long_pulse; held high 5 cycles; press_cnt=1.
- din high 9 samples then low -> short_pulse, no long_pulse; din high exactly 10 samples -> long_pulse after 10th sample, then release_pulse with short_pulse=0.
- din high 18 samples then low -> long_pulse at sample 10, repeat_pulse at samples 14 and 18, one release_pulse; repeat off (macro undefined) -> repeat_pulse never asserts.
- 257 one-sample presses separated by low samples -> press_cnt reads 1 (wrapped via 255 -> 0); every press produces exactly one press_pulse and one release_pulse.
- rst asserted during S_LONG with din=1 -> no release_pulse; after deassert, immediate press_pulse, press_cnt=1, new long_pulse after 10 samples.

Source files
------------

// File: rtl/key_event.sv
// Key event generator: turns a debounced key level into press/release/short/long/repeat pulses and a press count.
// Optional auto-repeat is enabled by defining KEY_EVENT_REPEAT_EN; without it repeat_pulse stays 0.
module key_event #(
    parameter int unsigned    N        = 26,
    parameter logic [N-1:0]   T_LONG   = N'(32'd50_000_000),
    parameter logic [N-1:0]   T_REPEAT = N'(32'd12_500_000),
    parameter int unsigned    CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    output logic          held,
    output logic          press_pulse,
    output logic          release_pulse,
    output logic          short_pulse,
    output logic          long_pulse,
    output logic          repeat_pulse,
    output logic [CW-1:0] press_cnt
);

    localparam logic [N-1:0] T_MAX = (T_LONG > T_REPEAT) ? T_LONG : T_REPEAT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_LONG  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0] press_cnt_q, press_cnt_d;
    logic          held_q, press_q, release_q, short_q, long_q, repeat_q;
    logic          press_d, release_d, short_d, long_d, repeat_d;

    // State, counter and all outputs are registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            press_cnt_q <= '0;
            held_q      <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_cnt_q <= press_cnt_d;
            held_q      <= (state_d != S_IDLE);
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    // Next-state, hold counter and pulse decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_cnt_d = press_cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        cnt_inc     = cnt_q + N'(1);

        case (state_q)
            S_IDLE: begin
                if (din) begin
                    state_d     = S_PRESS;
                    cnt_d       = N'(1);
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_PRESS: begin
                if (!din) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_inc == T_LONG) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LONG: begin
                if (!din) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_inc == T_REPEAT) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A counter beyond every threshold can only come from an upset; restart it
        if (cnt_d > T_MAX) begin
            cnt_d = '0;
        end
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed and random key patterns checked against a run-length event model.
module tb_key_event;

    localparam int unsigned N  = 26;
    localparam int unsigned CW = 8;
    localparam int          TL = 10;
    localparam int          TR = 4;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;
    logic [CW-1:0] press_cnt;

    int checks = 0;
    int errors = 0;
    int run    = 0;
    int pcnt   = 0;
    bit e_press, e_rel, e_short, e_long, e_rep;

    key_event #(
        .N(N), .T_LONG(N'(TL)), .T_REPEAT(N'(TR)), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .din(din),
        .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_pulse(short_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("held",      32'(held),          32'(run > 0));
        check("press",     32'(press_pulse),   32'(e_press));
        check("release",   32'(release_pulse), 32'(e_rel));
        check("short",     32'(short_pulse),   32'(e_short));
        check("long",      32'(long_pulse),    32'(e_long));
        check("repeat",    32'(repeat_pulse),  32'(e_rep));
        check("press_cnt", 32'(press_cnt),     32'(pcnt));
    endtask

    // One sampling edge: model events from the length of the current high run
    task automatic step(input logic d);
        din = d;
        @(posedge clk);
        #1;
        {e_press, e_rel, e_short, e_long, e_rep} = '0;
        if (rst) begin
            run  = 0;
            pcnt = 0;
        end else if (d) begin
            run++;
            if (run == 1) begin
                e_press = 1'b1;
                pcnt    = (pcnt + 1) % (1 << CW);
            end
            if (run == TL) e_long = 1'b1;
            if (REP_EN && run > TL && ((run - TL) % TR) == 0) e_rep = 1'b1;
        end else begin
            if (run > 0) begin
                e_rel   = 1'b1;
                e_short = (run < TL);
            end
            run = 0;
        end
        check_all();
    endtask

    task automatic hold(input int n, input logic d);
        for (int i = 0; i < n; i++) step(d);
    endtask

    task automatic reset_on();
        rst = 1'b1;
        #1;
        run  = 0;
        pcnt = 0;
        {e_press, e_rel, e_short, e_long, e_rep} = '0;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Short presses around the long threshold
        hold(5, 1'b1);  hold(3, 1'b0);
        check("cnt_after_first", 32'(press_cnt), 32'd1);
        hold(9, 1'b1);  hold(3, 1'b0);
        hold(10, 1'b1); hold(3, 1'b0);
        hold(18, 1'b1); hold(3, 1'b0);

        // Reset mid-run with din toggling, then din high at deassert
        hold(4, 1'b1);
        reset_on();
        for (int i = 0; i < 6; i++) step(logic'($urandom_range(0, 1)));
        rst = 1'b0;
        hold(3, 1'b1); hold(2, 1'b0);

        // Counter wrap over 257 one-sample presses
        reset_on();
        step(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            step(1'b1);
            step(1'b0);
        end
        check("cnt_wrap", 32'(press_cnt), 32'd1);

        // Reset while long-held, then a fresh press right after deassert
        hold(13, 1'b1);
        reset_on();
        step(1'b1);
        rst = 1'b0;
        hold(12, 1'b1); hold(2, 1'b0);
        check("cnt_after_long_rst", 32'(press_cnt), 32'd1);

        // Random press/release runs
        for (int i = 0; i < 60; i++) begin
            hold(int'($urandom_range(1, 24)), 1'b1);
            hold(int'($urandom_range(1, 4)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
